// File: rtl/deserializer_32_1bitin32bitout.sv
// -----------------------------------------------------------------------------
// deserializer_32_1bitin32bitout
//
// Purpose:
//   Collects single serial bits and steers each one into a 32-bit holding
//   word. An internal 5-bit index selects the target bit position. The
//   completed word is offered on a valid/ready interface. This is the
//   write-side counterpart of a 32:1 serializer mux.
//
// Parameters:
//   MSB_FIRST  0: first bit of a word lands at position 0, index counts up.
//              1: first bit of a word lands at position 31, index counts down.
//
// Ports:
//   clock       in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset
//   flush       in   1   synchronous abort of the partial or held word
//   bit_in      in   1   serial data bit
//   bit_valid   in   1   bit_in is valid this cycle
//   bit_ready   out  1   a bit can be accepted this cycle (combinational)
//   word_out    out  32  assembled word, meaningful while word_valid=1
//   word_valid  out  1   complete word held (registered)
//   word_ready  in   1   consumer takes the word this cycle
//   index       out  5   position the next accepted bit is written to
// -----------------------------------------------------------------------------
module deserializer_32_1bitin32bitout #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        bit_in,
   input  logic        bit_valid,
   output logic        bit_ready,
   output logic [31:0] word_out,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [4:0]  index
);

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_FULL    = 1'b1
   } state_t;

   localparam logic [4:0] FIRST_POS = MSB_FIRST ? 5'd31 : 5'd0;
   localparam logic [4:0] LAST_POS  = MSB_FIRST ? 5'd0  : 5'd31;

   state_t      r_state;
   logic [31:0] r_word;
   logic        r_word_valid;
   logic [4:0]  r_index;

   logic        w_bit_ready;
   logic        w_bit_take;
   logic        w_word_take;
   logic [4:0]  w_index_next;

   // A held word may be replaced in the same edge it is taken, so a waiting
   // consumer opens the bit path too; this is what allows gap-free words.
   // NOTE: continuous assigns give pure combinational logic with no path
   // through which a latch could be inferred.
   assign w_bit_ready  = (r_state == ST_COLLECT) || word_ready;
   assign w_bit_take   = bit_valid && w_bit_ready;
   assign w_word_take  = (r_state == ST_FULL) && word_ready;
   // 5-bit arithmetic wraps naturally, giving the modulo-32 step.
   assign w_index_next = MSB_FIRST ? (r_index - 5'd1) : (r_index + 5'd1);

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_COLLECT;
         r_word       <= 32'd0;
         r_word_valid <= 1'b0;
         r_index      <= FIRST_POS;
      end else if (flush) begin
         // Flush outranks both handshakes: nothing is accepted or transferred.
         r_state      <= ST_COLLECT;
         r_word       <= 32'd0;
         r_word_valid <= 1'b0;
         r_index      <= FIRST_POS;
      end else if (w_bit_take) begin
         // The first bit of a word also clears the remainder, so no stale
         // bits from the previous word survive. In FULL the index has
         // already wrapped to FIRST_POS, which covers the back-to-back case.
         if (r_index == FIRST_POS) begin
            r_word <= 32'(bit_in) << r_index;
         end else begin
            r_word[r_index] <= bit_in;
         end
         r_index <= w_index_next;
         if (r_index == LAST_POS) begin
            r_state      <= ST_FULL;
            r_word_valid <= 1'b1;
         end else begin
            r_state      <= ST_COLLECT;
            r_word_valid <= 1'b0;
         end
      end else if (w_word_take) begin
         // Word leaves without a new bit; the data stays as it was.
         r_state      <= ST_COLLECT;
         r_word_valid <= 1'b0;
      end
   end

   assign bit_ready  = w_bit_ready;
   assign word_out   = r_word;
   assign word_valid = r_word_valid;
   assign index      = r_index;

endmodule

// File: doc/deserializer_32_1bitin32bitout.md
# deserializer_32_1bitin32bitout

Collects a stream of single bits and steers each one into one of 32 bit positions of a holding word, selected by an internal 5-bit index counter. It then presents the completed 32-bit word on a valid/ready output. This is the write-side counterpart of the 32-to-1 bit mux used as a serializer: the mux selects one bit out of 32 by index, and this block routes one bit into 32 by index. It sits between a 1-bit serial source (debug/scan or serial link) and 32-bit datapath consumers such as a register write port or a memory fill buffer.

## Interface

Parameters:
- MSB_FIRST, default 0: bit position of each accepted bit.
  - 0: first bit goes to position 0, increasing.
  - 1: first bit goes to position 31, decreasing.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous abort; discards the partial or held word.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  block can accept a bit this cycle (combinational).
- word_out  out  32  assembled word; meaningful only while word_valid=1.
- word_valid  out  1  complete word held (registered).
- word_ready  in  1  consumer takes the word this cycle.
- index  out  5  bit position the next accepted bit will be written to (registered).

## Operation

- State machine, two states:
  - COLLECT: accepting bits.
  - FULL: word held, word_valid=1.
- Bit handshake: a bit is accepted on a rising edge when bit_valid && bit_ready.
  - bit_ready = (state==COLLECT) || word_ready. This allows back-to-back words.
- On bit acceptance:
  - word_out[index] <= bit_in.
  - If index is the first position (0, or 31 when MSB_FIRST=1), all other word_out bits are cleared to 0 in the same edge.
  - index then steps by +1 (MSB_FIRST=0) or −1 (MSB_FIRST=1), modulo 32.
- Word completion: accepting the bit at the last position (31, or 0 when MSB_FIRST=1):
  - moves COLLECT→FULL;
  - index wraps to the first position.
- Word handshake: the word transfers on a rising edge when word_valid && word_ready.
  - With no simultaneous bit: FULL→COLLECT, word_valid←0, word_out unchanged.
  - With a simultaneous accepted bit (bit_valid=1 in FULL with word_ready=1): the old word is transferred, the new bit is written at the first position, and the other bits are cleared. The state becomes COLLECT.
- The word held in FULL is stable: word_out does not change until it is transferred.
- flush=1 at an edge, with priority over both handshakes:
  - index←first position, word_out←0, word_valid←0, state←COLLECT;
  - any bit or word handshake in that cycle is ignored.
- Reset (asynchronous, at any time including mid-word or in FULL):
  - word_out=0, word_valid=0, index=first position (0, or 31 when MSB_FIRST=1), state=COLLECT;
  - bit_ready therefore reads 1 while reset is high and after it is released.

## Timing

- Latency: word_valid rises on the same edge that accepts the 32nd bit. word_out is complete in that cycle.
- Minimum word period: 32 cycles with bit_valid held high and word_ready held high. There are no bubbles between words.
- Backpressure: in FULL with word_ready=0, bit_ready=0. Bits offered then are not consumed and the source must hold them.
- bit_valid without bit_ready has no effect. word_ready without word_valid has no effect.
- index updates only on accepted bits, flush, or reset.
- word_ready=1 in COLLECT is ignored.

## Test plan

- **Reset mid-word:** accept 10 bits, assert reset asynchronously between edges -> word_out=0 and word_valid=0 immediately; index=0 and bit_ready=1 after release.
- **LSB-first assembly:** stream bits of 0xA5A5_0F3C LSB first with bit_valid held high and word_ready=0 -> word_valid=1 on the edge of bit 32, word_out=0xA5A50F3C, bit_ready=0.
  - Then pulse word_ready -> word_valid=0, index=0.
- **Back-to-back words:** word_ready tied 1, stream 0xFFFFFFFF then 0x00000001 continuously -> word_valid high exactly 1 cycle each, 32 cycles apart, carrying those values; no bit is lost.
- **MSB_FIRST=1:** stream 0x80000001 MSB first -> word_out=0x80000001; index sequence observed is 31,30,…,0,31.
- **Flush priority:** after 20 accepted bits, assert flush together with bit_valid=1 -> bit not taken, index=0, word_out=0. A following full 32-bit stream of 0x12345678 yields exactly 0x12345678.
- **Stall in FULL:** hold word_ready=0 for 5 cycles with bit_valid=1 -> word_out stable and bit_ready=0 throughout.
  - Then assert word_ready for 1 cycle -> word transfers and the pending bit lands at position 0 in that cycle.
